// File: rtl/wqe_pkg.sv
// Shared WQE layout and segmenter state encoding. The field positions are
// common to the WQE cache producer and the segmenter consumer.
package wqe_pkg;

  localparam int WRID_LSB   = 0;
  localparam int WRID_MSB   = 63;
  localparam int OPCODE_LSB = 64;
  localparam int OPCODE_MSB = 71;
  localparam int LEN_LSB    = 96;
  localparam int LEN_MSB    = 127;
  localparam int LADDR_LSB  = 128;
  localparam int LADDR_MSB  = 191;
  localparam int RADDR_LSB  = 192;
  localparam int RADDR_MSB  = 255;
  localparam int RKEY_LSB   = 256;
  localparam int RKEY_MSB   = 287;
  localparam int QPID_LSB   = 328;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEG  = 2'd2
  } seg_state_t;

endpackage

// File: rtl/wqe_segmenter.sv
// Pops WQEs from the WQE cache and splits each transfer into MTU-bounded
// segment requests, then pulses a completion after the last one is accepted.
module wqe_segmenter
  import wqe_pkg::*;
#(
  parameter int WQE_WIDTH    = 512,
  parameter int QP_PTR_WIDTH = 4,
  parameter int MTU_LOG2     = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    o_wqe_cache_rd,
  input  logic                    i_wqe_cache_empty,
  input  logic                    i_wqe_val,
  input  logic [WQE_WIDTH-1:0]    i_wqe,
  output logic                    o_seg_val,
  input  logic                    i_seg_rdy,
  output logic [QP_PTR_WIDTH-1:0] o_seg_qpn,
  output logic [7:0]              o_seg_opcode,
  output logic [63:0]             o_seg_laddr,
  output logic [63:0]             o_seg_raddr,
  output logic [31:0]             o_seg_rkey,
  output logic [MTU_LOG2:0]       o_seg_len,
  output logic                    o_seg_first,
  output logic                    o_seg_last,
  output logic                    o_cmpl_val,
  output logic [63:0]             o_cmpl_wrid,
  output logic [QP_PTR_WIDTH-1:0] o_cmpl_qpn
);

  localparam logic [31:0] MTU_BYTES = 32'd1 << MTU_LOG2;
  localparam logic [63:0] MTU_ADDR  = 64'd1 << MTU_LOG2;

  seg_state_t  state, state_next;
  logic        rd_next, latch, advance, done;
  logic [31:0] rem, rem_step, wqe_len;
  logic [63:0] wrid;
  logic        unused_wqe_bits;

  assign wqe_len  = i_wqe[LEN_MSB:LEN_LSB];
  assign rem_step = rem - MTU_BYTES;

  assign unused_wqe_bits = ^{i_wqe[LEN_LSB-1:OPCODE_MSB+1],
                             i_wqe[QPID_LSB-1:RKEY_MSB+1],
                             i_wqe[WQE_WIDTH-1:QPID_LSB+QP_PTR_WIDTH]};

  function automatic logic [MTU_LOG2:0] seg_len_of(input logic [31:0] r);
    return (r > MTU_BYTES) ? MTU_BYTES[MTU_LOG2:0] : r[MTU_LOG2:0];
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_next = state;
    rd_next    = 1'b0;
    latch      = 1'b0;
    advance    = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!i_wqe_cache_empty) begin
          rd_next    = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_wqe_val) begin
          latch      = 1'b1;
          state_next = ST_SEG;
        end
      end
      ST_SEG: begin
        if (o_seg_val && i_seg_rdy) begin
          if (o_seg_last) begin
            done = 1'b1;
            // Pop the next WQE in the completion cycle rather than idling one cycle first.
            if (!i_wqe_cache_empty) begin
              rd_next    = 1'b1;
              state_next = ST_WAIT;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Length and last flag are precomputed for the rem held next cycle so they leave a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_wqe_cache_rd <= 1'b0;
      o_seg_val      <= 1'b0;
      rem            <= '0;
      wrid           <= '0;
      o_seg_qpn      <= '0;
      o_seg_opcode   <= '0;
      o_seg_laddr    <= '0;
      o_seg_raddr    <= '0;
      o_seg_rkey     <= '0;
      o_seg_len      <= '0;
      o_seg_first    <= 1'b0;
      o_seg_last     <= 1'b0;
      o_cmpl_val     <= 1'b0;
      o_cmpl_wrid    <= '0;
      o_cmpl_qpn     <= '0;
    end else begin
      o_wqe_cache_rd <= rd_next;
      o_seg_val      <= (state_next == ST_SEG);
      o_cmpl_val     <= done;
      if (latch) begin
        rem          <= wqe_len;
        wrid         <= i_wqe[WRID_MSB:WRID_LSB];
        o_seg_qpn    <= i_wqe[QPID_LSB +: QP_PTR_WIDTH];
        o_seg_opcode <= i_wqe[OPCODE_MSB:OPCODE_LSB];
        o_seg_laddr  <= i_wqe[LADDR_MSB:LADDR_LSB];
        o_seg_raddr  <= i_wqe[RADDR_MSB:RADDR_LSB];
        o_seg_rkey   <= i_wqe[RKEY_MSB:RKEY_LSB];
        o_seg_len    <= seg_len_of(wqe_len);
        o_seg_first  <= 1'b1;
        o_seg_last   <= (wqe_len <= MTU_BYTES);
      end else if (advance) begin
        rem          <= rem_step;
        o_seg_laddr  <= o_seg_laddr + MTU_ADDR;
        o_seg_raddr  <= o_seg_raddr + MTU_ADDR;
        o_seg_len    <= seg_len_of(rem_step);
        o_seg_first  <= 1'b0;
        o_seg_last   <= (rem_step <= MTU_BYTES);
      end
      if (done) begin
        o_cmpl_wrid <= wrid;
        o_cmpl_qpn  <= o_seg_qpn;
      end
    end
  end

endmodule

// File: tb/tb_wqe_segmenter.sv
// Self-checking bench: a WQE cache model feeds the segmenter, and a scoreboard
// expands each delivered WQE into its expected segments and completion.
module tb_wqe_segmenter;

  localparam int MTU = 4096;

  typedef struct packed {
    logic [63:0] wrid;
    logic [7:0]  op;
    logic [31:0] len;
    logic [63:0] laddr;
    logic [63:0] raddr;
    logic [31:0] rkey;
    logic [3:0]  qpn;
  } wqe_t;

  typedef struct packed {
    logic [3:0]  qpn;
    logic [7:0]  op;
    logic [63:0] laddr;
    logic [63:0] raddr;
    logic [31:0] rkey;
    logic [12:0] len;
    logic        first;
    logic        last;
  } seg_t;

  typedef struct packed {
    logic [63:0] wrid;
    logic [3:0]  qpn;
  } cmpl_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         o_wqe_cache_rd;
  logic         i_wqe_cache_empty = 1'b1;
  logic         i_wqe_val = 1'b0;
  logic [511:0] i_wqe = '0;
  logic         o_seg_val;
  logic         i_seg_rdy = 1'b0;
  logic [3:0]   o_seg_qpn;
  logic [7:0]   o_seg_opcode;
  logic [63:0]  o_seg_laddr;
  logic [63:0]  o_seg_raddr;
  logic [31:0]  o_seg_rkey;
  logic [12:0]  o_seg_len;
  logic         o_seg_first;
  logic         o_seg_last;
  logic         o_cmpl_val;
  logic [63:0]  o_cmpl_wrid;
  logic [3:0]   o_cmpl_qpn;

  wqe_segmenter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .o_wqe_cache_rd    (o_wqe_cache_rd),
    .i_wqe_cache_empty (i_wqe_cache_empty),
    .i_wqe_val         (i_wqe_val),
    .i_wqe             (i_wqe),
    .o_seg_val         (o_seg_val),
    .i_seg_rdy         (i_seg_rdy),
    .o_seg_qpn         (o_seg_qpn),
    .o_seg_opcode      (o_seg_opcode),
    .o_seg_laddr       (o_seg_laddr),
    .o_seg_raddr       (o_seg_raddr),
    .o_seg_rkey        (o_seg_rkey),
    .o_seg_len         (o_seg_len),
    .o_seg_first       (o_seg_first),
    .o_seg_last        (o_seg_last),
    .o_cmpl_val        (o_cmpl_val),
    .o_cmpl_wrid       (o_cmpl_wrid),
    .o_cmpl_qpn        (o_cmpl_qpn)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench state shared between the cache driver, the checker and the sequencer.
  wqe_t  cache_q[$];
  seg_t  seg_q[$];
  seg_t  log_q[$];
  int    log_cyc[$];
  cmpl_t cmpl_log[$];
  wqe_t  pend_w;
  bit    pend = 0;
  int    dly = 0;
  int    deliv_cyc = -10;
  bit    cmpl_due = 0;
  cmpl_t exp_cmpl;
  int    rdy_mode = 0;
  bit    delay_en = 0;
  bit    stray_en = 0;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] pack(input wqe_t w);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    d[63:0]    = w.wrid;
    d[71:64]   = w.op;
    d[127:96]  = w.len;
    d[191:128] = w.laddr;
    d[255:192] = w.raddr;
    d[287:256] = w.rkey;
    d[331:328] = w.qpn;
    return d;
  endfunction

  // Reference: a WQE of L bytes becomes max(1, ceil(L/MTU)) segments, segment k at base + k*MTU.
  function automatic void expand(input wqe_t w);
    seg_t s;
    int   nseg;
    longint unsigned left;
    nseg = (w.len == 0) ? 1 : int'((longint'(w.len) + MTU - 1) / MTU);
    for (int k = 0; k < nseg; k++) begin
      left    = longint'(w.len) - longint'(k) * MTU;
      s.qpn   = w.qpn;
      s.op    = w.op;
      s.rkey  = w.rkey;
      s.laddr = w.laddr + 64'(k) * 64'(MTU);
      s.raddr = w.raddr + 64'(k) * 64'(MTU);
      s.len   = (left > MTU) ? 13'(MTU) : 13'(left);
      s.first = (k == 0);
      s.last  = (k == nseg - 1);
      seg_q.push_back(s);
    end
    exp_cmpl.wrid = w.wrid;
    exp_cmpl.qpn  = w.qpn;
  endfunction

  function automatic wqe_t mk(input logic [63:0] wrid, input logic [3:0] qpn,
                              input logic [31:0] len, input logic [63:0] laddr);
    wqe_t w;
    w.wrid  = wrid;
    w.op    = 8'h0A;
    w.len   = len;
    w.laddr = laddr;
    w.raddr = 64'h0000_00AB_0000_0000 + laddr;
    w.rkey  = 32'hC0DE_0000 | 32'(qpn);
    w.qpn   = qpn;
    return w;
  endfunction

  function automatic wqe_t rand_wqe();
    wqe_t w;
    w.wrid  = {$urandom, $urandom};
    w.op    = 8'($urandom);
    w.rkey  = $urandom;
    w.qpn   = 4'($urandom);
    w.laddr = {$urandom, $urandom};
    w.raddr = {$urandom, $urandom};
    if ($urandom_range(3) == 0) w.laddr = {32'hFFFF_FFFF, 20'hFFFFF, 12'($urandom)};
    case ($urandom_range(5))
      0:       w.len = 0;
      1:       w.len = $urandom_range(1, MTU);
      2:       w.len = MTU;
      3:       w.len = MTU + 1;
      4:       w.len = $urandom_range(MTU + 1, 20000);
      default: w.len = 2 * MTU;
    endcase
    return w;
  endfunction

  // Cache model and segment-ready driver: inputs change 1 time unit after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        i_wqe_val = 1'b0;
        i_seg_rdy = 1'b0;
        pend = 0;
        i_wqe_cache_empty = (cache_q.size() == 0);
        continue;
      end
      i_wqe_val = 1'b0;
      if (pend) begin
        if (dly == 0) begin
          i_wqe_val = 1'b1;
          i_wqe     = pack(pend_w);
          expand(pend_w);
          pend      = 0;
          deliv_cyc = cyc;
        end else begin
          dly--;
        end
      end else if (stray_en && o_seg_val && $urandom_range(7) == 0) begin
        i_wqe_val = 1'b1;
        for (int i = 0; i < 16; i++) i_wqe[i*32 +: 32] = $urandom;
      end
      if (o_wqe_cache_rd) begin
        check("pop_legal", {cache_q.size() == 0, pend, seg_q.size() != 0}, 3'b000);
        if (cache_q.size() != 0 && !pend) begin
          pend_w = cache_q.pop_front();
          pend   = 1;
          dly    = (delay_en && $urandom_range(3) == 0) ? $urandom_range(1, 3) : 0;
        end
      end
      i_wqe_cache_empty = (cache_q.size() == 0);
      case (rdy_mode)
        0:       i_seg_rdy = 1'b1;
        1:       i_seg_rdy = ($urandom_range(3) != 0);
        default: i_seg_rdy = 1'b0;
      endcase
    end
  end

  // Compare process: outputs are sampled on the falling edge.
  seg_t held;
  bit   prev_stall = 0;
  initial begin
    seg_t act, e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
        cmpl_due   = 0;
        continue;
      end
      act = {o_seg_qpn, o_seg_opcode, o_seg_laddr, o_seg_raddr, o_seg_rkey,
             o_seg_len, o_seg_first, o_seg_last};
      if (cyc == deliv_cyc + 1) check("seg_latency", o_seg_val, 1'b1);
      if (cmpl_due)
        check("cmpl", {o_cmpl_val, o_cmpl_wrid, o_cmpl_qpn}, {1'b1, exp_cmpl});
      else
        check("cmpl_idle", o_cmpl_val, 1'b0);
      if (cmpl_due && o_cmpl_val) cmpl_log.push_back({o_cmpl_wrid, o_cmpl_qpn});
      cmpl_due = 0;
      if (prev_stall) check("stall_hold", {o_seg_val, act}, {1'b1, held});
      if (o_seg_val && i_seg_rdy) begin
        if (seg_q.size() == 0) begin
          check("seg_unexpected", o_seg_val, 1'b0);
        end else begin
          e = seg_q.pop_front();
          check("seg", act, e);
          if (e.last) cmpl_due = 1;
        end
        log_q.push_back(act);
        log_cyc.push_back(cyc);
      end
      prev_stall = o_seg_val && !i_seg_rdy;
      held       = act;
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (!(cache_q.size() == 0 && !pend && seg_q.size() == 0 && !cmpl_due) && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("drain_timeout", n < budget, 1'b1);
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic wait_log(input int count, input int budget);
    int n;
    n = 0;
    while (log_q.size() < count && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("log_timeout", n < budget, 1'b1);
  endtask

  task automatic clear_logs();
    log_q.delete();
    log_cyc.delete();
    cmpl_log.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {o_wqe_cache_rd, o_seg_val, o_seg_qpn, o_seg_opcode, o_seg_laddr, o_seg_raddr,
           o_seg_rkey, o_seg_len, o_seg_first, o_seg_last, o_cmpl_val, o_cmpl_wrid, o_cmpl_qpn},
          258'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single short WQE.
    clear_logs();
    cache_q.push_back(mk(64'hA1, 4'd1, 32'd100, 64'h1000));
    wait_drain(200);
    check("t1_nseg", log_q.size(), 1);
    check("t1_seg", {log_q[0].len, log_q[0].first, log_q[0].last, log_q[0].laddr},
          {13'd100, 1'b1, 1'b1, 64'h1000});
    check("t1_cmpl", {cmpl_log.size() == 1, cmpl_log[0]}, {1'b1, 64'hA1, 4'd1});

    // 10000 bytes: 4096/4096/1808, back-to-back.
    clear_logs();
    cache_q.push_back(mk(64'hA2, 4'd2, 32'd10000, 64'h0));
    wait_drain(200);
    check("t2_nseg", log_q.size(), 3);
    check("t2_len", {log_q[0].len, log_q[1].len, log_q[2].len}, {13'd4096, 13'd4096, 13'd1808});
    check("t2_laddr", {log_q[0].laddr, log_q[1].laddr, log_q[2].laddr},
          {64'h0, 64'h1000, 64'h2000});
    check("t2_flags", {log_q[0].first, log_q[1].first, log_q[2].first,
                       log_q[0].last, log_q[1].last, log_q[2].last}, 6'b100_001);
    check("t2_b2b", {log_cyc[1] - log_cyc[0], log_cyc[2] - log_cyc[1]}, {32'd1, 32'd1});

    // Zero-length WQE.
    clear_logs();
    cache_q.push_back(mk(64'hA3, 4'd3, 32'd0, 64'h5000));
    wait_drain(200);
    check("t3_seg", {log_q.size() == 1, log_q[0].len, log_q[0].first, log_q[0].last},
          {1'b1, 13'd0, 1'b1, 1'b1});
    check("t3_ncmpl", cmpl_log.size(), 1);

    // Backpressure for 5 cycles on segment 2.
    clear_logs();
    cache_q.push_back(mk(64'hA4, 4'd4, 32'd12288, 64'h8000));
    wait_log(1, 200);
    rdy_mode = 2;
    repeat (5) @(negedge clk);
    rdy_mode = 0;
    wait_drain(200);
    check("t4_nseg", log_q.size(), 3);
    check("t4_laddr", {log_q[0].laddr, log_q[1].laddr, log_q[2].laddr},
          {64'h8000, 64'h9000, 64'hA000});
    check("t4_gap", log_cyc[1] - log_cyc[0], 6);

    // Address wrap.
    clear_logs();
    cache_q.push_back(mk(64'hA5, 4'd5, 32'd8192, 64'hFFFF_FFFF_FFFF_F000));
    wait_drain(200);
    check("t5_wrap", {log_q.size() == 2, log_q[1].laddr, log_q[1].last}, {1'b1, 64'h0, 1'b1});

    // Reset during segment 2 of A; B is then processed alone.
    clear_logs();
    cache_q.push_back(mk(64'hAA, 4'd6, 32'd16384, 64'h10000));
    cache_q.push_back(mk(64'hBB, 4'd7, 32'd5000, 64'h20000));
    wait_log(1, 200);
    rdy_mode = 2;
    repeat (2) @(negedge clk);
    check("t6_pre_reset", log_q.size(), 1);
    rst_n = 1'b0;
    #1;
    check("t6_reset_outputs",
          {o_wqe_cache_rd, o_seg_val, o_seg_qpn, o_seg_opcode, o_seg_laddr, o_seg_raddr,
           o_seg_rkey, o_seg_len, o_seg_first, o_seg_last, o_cmpl_val, o_cmpl_wrid, o_cmpl_qpn},
          258'd0);
    seg_q.delete();
    cmpl_due = 0;
    deliv_cyc = -10;
    clear_logs();
    repeat (3) @(negedge clk);
    rdy_mode = 0;
    rst_n = 1'b1;
    wait_drain(200);
    check("t6_b_segs", {log_q.size() == 2, log_q[0].len, log_q[0].first, log_q[1].len},
          {1'b1, 13'd4096, 1'b1, 13'd904});
    check("t6_cmpl", {cmpl_log.size() == 1, cmpl_log[0]}, {1'b1, 64'hBB, 4'd7});

    // Randomized traffic with random ready, delayed pop data and stray valids.
    rdy_mode = 1;
    delay_en = 1;
    stray_en = 1;
    for (int i = 0; i < 40; i++) begin
      cache_q.push_back(rand_wqe());
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_drain(20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wqe_segmenter.md
# wqe_segmenter

Consumer end of the WQE cache. Pops one WQE at a time through the cache read interface, decodes its fields, and splits the transfer into MTU-bounded segment requests for the TX DMA/packet builder. When the last segment of a WQE is accepted, it pulses a completion carrying the WQE's wrid and QP number. It sits between the WQE cache and the TX payload fetch engine.

## Interface
- WQE_WIDTH, 512, WQE bit width.
- QP_PTR_WIDTH, 4, QP number width.
- MTU_LOG2, 12, log2 of max segment bytes (4096).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- o_wqe_cache_rd  out  1  pop request to WQE cache, single-cycle pulse.
- i_wqe_cache_empty  in  1  cache has no WQE.
- i_wqe_val  in  1  popped WQE valid; arrives exactly 1 cycle after o_wqe_cache_rd.
- i_wqe  in  WQE_WIDTH  popped WQE data, sampled when i_wqe_val=1.
- o_seg_val  out  1  segment request valid.
- i_seg_rdy  in  1  downstream accepts segment.
- o_seg_qpn  out  QP_PTR_WIDTH  QP of segment.
- o_seg_opcode  out  8  WQE opcode.
- o_seg_laddr  out  64  local address of segment.
- o_seg_raddr  out  64  remote address of segment.
- o_seg_rkey  out  32  remote key.
- o_seg_len  out  MTU_LOG2+1  segment byte count.
- o_seg_first  out  1  first segment of WQE.
- o_seg_last  out  1  last segment of WQE.
- o_cmpl_val  out  1  one-cycle completion pulse.
- o_cmpl_wrid  out  64  wrid of completed WQE.
- o_cmpl_qpn  out  QP_PTR_WIDTH  QP of completed WQE.

## Operation
- WQE fields: wrid[63:0], opcode[71:64], length[127:96] (32b bytes), laddr[191:128], raddr[255:192], rkey[287:256], qpn[328 +: QP_PTR_WIDTH].
- FSM states:
  - IDLE: if i_wqe_cache_empty=0, assert o_wqe_cache_rd for one cycle and go to WAIT.
  - WAIT: on i_wqe_val, latch all fields, set rem=length, first=1, and go to SEG.
  - SEG: drive o_seg_val=1. On o_seg_val&i_seg_rdy:
    - if rem<=2^MTU_LOG2, this is the last segment; go to IDLE.
    - otherwise rem-=2^MTU_LOG2, laddr and raddr each +=2^MTU_LOG2, first←0.
- o_seg_len=min(rem, 2^MTU_LOG2). o_seg_last=(rem<=2^MTU_LOG2).
- length=0 WQE: one segment, len=0, first=last=1.
- Address arithmetic is modulo 2^64 (wraps silently). rem is 32-bit unsigned.
- o_cmpl_val pulses in the cycle after the last segment's handshake, with the latched wrid/qpn. It has no backpressure.
- No read is issued while a WQE is held. At most one outstanding pop.
- i_wqe_val arriving outside WAIT is ignored.
- If i_wqe_val is not seen in the cycle after the pop, WAIT holds until it arrives.

## Timing
- Reset values: all outputs 0, state=IDLE, latched fields 0.
- Reset mid-operation: the current WQE is dropped and no completion is issued.
- Pop at cycle T → i_wqe_val at T+1 → o_seg_val high at T+2.
- Segments stream back-to-back at one per cycle while i_seg_rdy=1.
- All o_seg_* fields stay stable while o_seg_val=1 and i_seg_rdy=0.
- Last handshake at cycle L → o_cmpl_val at L+1 → earliest next pop at L+1 (from IDLE, if not empty).
- All outputs are registered.

## Structure
- Shared package wqe_pkg holds:
  - WQE field LSB/MSB constants (WRID, OPCODE, LEN, LADDR, RADDR, RKEY, QPID_LSB=328), also used by the cache.
  - the FSM state encoding.
- Single module, no sub-module. Segment length and last-segment compare are inline logic.

## Test plan
- Single WQE, qpn=1, length=100, laddr=0x1000 → one segment: len=100, first=last=1, laddr=0x1000. Then cmpl wrid matches, qpn=1.
- length=10000, MTU 4096, rdy=1 → three segments of 4096/4096/1808 on consecutive cycles, laddr 0x0/0x1000/0x2000, first only on #1, last only on #3.
- length=0 → one segment len=0, first=last=1. One completion.
- Backpressure: rdy=0 for 5 cycles mid-WQE → seg fields held constant, no segment skipped or duplicated.
- laddr=0xFFFF_FFFF_FFFF_F000, length=8192 → second segment laddr=0x0.
- Two queued WQEs, then rst_n low during segment 2 of WQE A → all outputs 0 immediately. After release, WQE B is processed fresh with no completion for A.
